// File: rtl/axi_rd_arbiter_if.sv
// Bundle of the two requester read ports and the shared slave read port.
// The arbiter uses the slave modport; the requester/slave-model side uses master.
interface axi_rd_arbiter_if #(
  parameter int ADDR_BITS = 32,
  parameter int LEN_BITS  = 8,
  parameter int SIZE_BITS = 3,
  parameter int DATA_BITS = 32
);
  logic [1:0]             m_ar_valid;
  logic [1:0]             m_ar_ready;
  logic [2*ADDR_BITS-1:0] m_ar_addr;
  logic [2*LEN_BITS-1:0]  m_ar_len;
  logic [2*SIZE_BITS-1:0] m_ar_size;
  logic [3:0]             m_ar_burst;
  logic [7:0]             m_ar_cache;
  logic [1:0]             m_r_valid;
  logic [1:0]             m_r_ready;
  logic [DATA_BITS-1:0]   m_r_data;
  logic                   m_r_last;
  logic [1:0]             m_r_resp;

  logic                   s_ar_valid;
  logic                   s_ar_ready;
  logic [ADDR_BITS-1:0]   s_ar_addr;
  logic [LEN_BITS-1:0]    s_ar_len;
  logic [SIZE_BITS-1:0]   s_ar_size;
  logic [1:0]             s_ar_burst;
  logic [3:0]             s_ar_cache;
  logic                   s_r_valid;
  logic                   s_r_ready;
  logic [DATA_BITS-1:0]   s_r_data;
  logic                   s_r_last;
  logic [1:0]             s_r_resp;

  modport slave (
    input  m_ar_valid, m_ar_addr, m_ar_len, m_ar_size, m_ar_burst, m_ar_cache, m_r_ready,
    output m_ar_ready, m_r_valid, m_r_data, m_r_last, m_r_resp,
    output s_ar_valid, s_ar_addr, s_ar_len, s_ar_size, s_ar_burst, s_ar_cache, s_r_ready,
    input  s_ar_ready, s_r_valid, s_r_data, s_r_last, s_r_resp
  );

  modport master (
    output m_ar_valid, m_ar_addr, m_ar_len, m_ar_size, m_ar_burst, m_ar_cache, m_r_ready,
    input  m_ar_ready, m_r_valid, m_r_data, m_r_last, m_r_resp,
    input  s_ar_valid, s_ar_addr, s_ar_len, s_ar_size, s_ar_burst, s_ar_cache, s_r_ready,
    output s_ar_ready, s_r_valid, s_r_data, s_r_last, s_r_resp
  );
endinterface

// File: rtl/axi_rd_arbiter.sv
// Two-master round-robin read arbiter: one AR+R burst at a time is routed
// between the granted requester and the slave; grant held until the last beat.
module axi_rd_arbiter #(
  parameter int ADDR_BITS = 32,
  parameter int LEN_BITS  = 8,
  parameter int SIZE_BITS = 3,
  parameter int DATA_BITS = 32
) (
  input  logic              aclk,
  input  logic              areset,
  axi_rd_arbiter_if.slave   bus,
  output logic [1:0]        gnt,
  output logic              proto_err
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ADDR = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;

  logic [1:0]          r_state;
  logic [1:0]          r_gnt;
  logic                r_last_grant;
  logic [LEN_BITS-1:0] r_beats_left;
  logic                r_proto_err;

  logic                w_g;
  logic [1:0]          w_pick;
  logic                w_ar_hs;
  logic                w_r_hs;
  logic [LEN_BITS-1:0] w_len_sel;
  logic                w_beat_err;

  assign w_g = r_gnt[1];

  // Tie goes to the master that did not own the previous burst.
  always_comb begin
    w_pick = 2'b00;
    if (bus.m_ar_valid == 2'b11) begin
      w_pick = r_last_grant ? 2'b01 : 2'b10;
    end else begin
      w_pick = bus.m_ar_valid;
    end
  end

  assign bus.s_ar_valid = (r_state == ST_ADDR);
  assign bus.s_ar_addr  = w_g ? bus.m_ar_addr[2*ADDR_BITS-1:ADDR_BITS] : bus.m_ar_addr[ADDR_BITS-1:0];
  assign bus.s_ar_len   = w_len_sel;
  assign bus.s_ar_size  = w_g ? bus.m_ar_size[2*SIZE_BITS-1:SIZE_BITS] : bus.m_ar_size[SIZE_BITS-1:0];
  assign bus.s_ar_burst = w_g ? bus.m_ar_burst[3:2] : bus.m_ar_burst[1:0];
  assign bus.s_ar_cache = w_g ? bus.m_ar_cache[7:4] : bus.m_ar_cache[3:0];
  assign w_len_sel      = w_g ? bus.m_ar_len[2*LEN_BITS-1:LEN_BITS] : bus.m_ar_len[LEN_BITS-1:0];

  assign bus.m_r_data = bus.s_r_data;
  assign bus.m_r_last = bus.s_r_last;
  assign bus.m_r_resp = bus.s_r_resp;

  // Handshake steering toward the granted master only.
  always_comb begin
    bus.m_ar_ready = 2'b00;
    bus.m_r_valid  = 2'b00;
    bus.s_r_ready  = 1'b0;
    if (r_state == ST_ADDR) begin
      bus.m_ar_ready = w_g ? {bus.s_ar_ready, 1'b0} : {1'b0, bus.s_ar_ready};
    end else if (r_state == ST_DATA) begin
      bus.m_r_valid = w_g ? {bus.s_r_valid, 1'b0} : {1'b0, bus.s_r_valid};
      bus.s_r_ready = bus.m_r_ready[w_g];
    end else begin
      bus.m_ar_ready = 2'b00;
    end
  end

  assign w_ar_hs    = bus.s_ar_valid && bus.s_ar_ready;
  assign w_r_hs     = bus.s_r_valid && bus.s_r_ready;
  assign w_beat_err = (bus.s_r_last && (r_beats_left != '0)) ||
                      (!bus.s_r_last && (r_beats_left == '0));

  always_ff @(posedge aclk) begin
    if (areset) begin
      r_state      <= ST_IDLE;
      r_gnt        <= 2'b00;
      r_last_grant <= 1'b1;
      r_beats_left <= '0;
      r_proto_err  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_pick != 2'b00) begin
            r_gnt   <= w_pick;
            r_state <= ST_ADDR;
          end
        end
        ST_ADDR: begin
          if (w_ar_hs) begin
            r_beats_left <= w_len_sel;
            r_state      <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (w_r_hs) begin
            r_beats_left <= r_beats_left - {{(LEN_BITS-1){1'b0}}, 1'b1};
            if (w_beat_err) begin
              r_proto_err <= 1'b1;
            end
            // Only r_last ends the burst, even if the count disagreed.
            if (bus.s_r_last) begin
              r_last_grant <= w_g;
              r_gnt        <= 2'b00;
              r_state      <= ST_IDLE;
            end
          end
        end
        default: begin
          r_gnt   <= 2'b00;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign gnt       = r_gnt;
  assign proto_err = r_proto_err;

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Directed bench for axi_rd_arbiter: the bench plays both requesters and the slave.
module tb_axi_rd_arbiter;
  logic       aclk;
  logic       areset;
  logic [1:0] gnt;
  logic       proto_err;
  int         checks;
  int         failures;

  axi_rd_arbiter_if #(.ADDR_BITS(32), .LEN_BITS(8), .SIZE_BITS(3), .DATA_BITS(32)) bus ();

  axi_rd_arbiter #(.ADDR_BITS(32), .LEN_BITS(8), .SIZE_BITS(3), .DATA_BITS(32)) dut (
    .aclk      (aclk),
    .areset    (areset),
    .bus       (bus),
    .gnt       (gnt),
    .proto_err (proto_err)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    areset = 1'b1;
    tick();
    tick();
    areset = 1'b0;
  endtask

  // Wait one edge from IDLE (request already up), check grant and payload, then handshake.
  task automatic do_ar(input logic [1:0] g, input logic [31:0] addr, input logic [7:0] len);
    tick();
    chk("ar_gnt", {62'd0, gnt}, {62'd0, g});
    chk("ar_valid", {63'd0, bus.s_ar_valid}, 64'd1);
    chk("ar_addr", {32'd0, bus.s_ar_addr}, {32'd0, addr});
    chk("ar_len", {56'd0, bus.s_ar_len}, {56'd0, len});
    bus.s_ar_ready = 1'b1;
    #1;
    chk("ar_ready", {62'd0, bus.m_ar_ready}, {62'd0, g});
    tick();
    bus.s_ar_ready = 1'b0;
  endtask

  // Drive n beats, r_last on beat index last_at, checking routing of each beat.
  task automatic run_beats(input logic [1:0] g, input int n, input int last_at, input logic [31:0] base);
    for (int b = 0; b < n; b++) begin
      bus.s_r_valid = 1'b1;
      bus.s_r_data  = base + 32'(b);
      bus.s_r_last  = (b == last_at);
      #1;
      chk("r_valid", {62'd0, bus.m_r_valid}, {62'd0, g});
      chk("r_data", {32'd0, bus.m_r_data}, {32'd0, base + 32'(b)});
      chk("r_ar_ready_idle", {62'd0, bus.m_ar_ready}, 64'd0);
      tick();
    end
    bus.s_r_valid = 1'b0;
    bus.s_r_last  = 1'b0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    areset   = 1'b1;
    bus.m_ar_valid = 2'b00;
    bus.m_ar_addr  = 64'd0;
    bus.m_ar_len   = 16'd0;
    bus.m_ar_size  = 6'b010_010;
    bus.m_ar_burst = 4'b01_01;
    bus.m_ar_cache = 8'h00;
    bus.m_r_ready  = 2'b11;
    bus.s_ar_ready = 1'b0;
    bus.s_r_valid  = 1'b0;
    bus.s_r_data   = 32'd0;
    bus.s_r_last   = 1'b0;
    bus.s_r_resp   = 2'b00;

    // Reset state
    do_reset();
    chk("rst_gnt", {62'd0, gnt}, 64'd0);
    chk("rst_ar_valid", {63'd0, bus.s_ar_valid}, 64'd0);
    chk("rst_r_ready", {63'd0, bus.s_r_ready}, 64'd0);
    chk("rst_proto_err", {63'd0, proto_err}, 64'd0);
    bus.s_r_valid = 1'b1;
    #1;
    chk("idle_no_r_accept", {63'd0, bus.s_r_ready}, 64'd0);
    chk("idle_no_r_route", {62'd0, bus.m_r_valid}, 64'd0);
    bus.s_r_valid = 1'b0;

    // Single master 0, len 0, addr 0x10
    bus.m_ar_addr  = {32'h0, 32'h0000_0010};
    bus.m_ar_len   = 16'h0000;
    bus.m_ar_valid = 2'b01;
    #1;
    chk("t1_pre_ar_valid", {63'd0, bus.s_ar_valid}, 64'd0);
    do_ar(2'b01, 32'h10, 8'd0);
    bus.m_ar_valid = 2'b00;
    bus.s_r_resp   = 2'b10;
    #1;
    chk("t1_ar_valid_off", {63'd0, bus.s_ar_valid}, 64'd0);
    chk("t1_r_ready_open", {63'd0, bus.s_r_ready}, 64'd1);
    bus.s_r_valid = 1'b1;
    bus.s_r_last  = 1'b1;
    bus.s_r_data  = 32'hA5A5_0001;
    #1;
    chk("t1_m_r_valid", {62'd0, bus.m_r_valid}, 64'd1);
    chk("t1_m_r_last", {63'd0, bus.m_r_last}, 64'd1);
    chk("t1_m_r_resp", {62'd0, bus.m_r_resp}, 64'd2);
    tick();
    bus.s_r_valid = 1'b0;
    bus.s_r_last  = 1'b0;
    bus.s_r_resp  = 2'b00;
    chk("t1_gnt_idle", {62'd0, gnt}, 64'd0);
    chk("t1_proto_err", {63'd0, proto_err}, 64'd0);
    chk("t1_r_ready_idle", {63'd0, bus.s_r_ready}, 64'd0);

    // Both masters continuously, len 3 each: grants alternate starting with master 0
    do_reset();
    bus.m_ar_addr  = {32'h0000_2000, 32'h0000_1000};
    bus.m_ar_len   = {8'd3, 8'd3};
    bus.m_ar_valid = 2'b11;
    for (int k = 0; k < 4; k++) begin
      logic [1:0] eg;
      eg = (k % 2 == 0) ? 2'b01 : 2'b10;
      do_ar(eg, (k % 2 == 0) ? 32'h1000 : 32'h2000, 8'd3);
      run_beats(eg, 4, 3, 32'h100 * 32'(k));
      chk("t2_gnt_released", {62'd0, gnt}, 64'd0);
    end
    chk("t2_proto_err", {63'd0, proto_err}, 64'd0);

    // Master 1 arrives mid master-0 burst; previous owner was master 1
    bus.m_ar_valid = 2'b01;
    bus.m_ar_addr  = {32'h0000_0400, 32'h0000_0300};
    bus.m_ar_len   = {8'd1, 8'd3};
    do_ar(2'b01, 32'h300, 8'd3);
    bus.m_ar_valid = 2'b00;
    run_beats(2'b01, 1, 3, 32'h3000);
    bus.m_ar_valid = 2'b10;
    for (int b = 1; b < 4; b++) begin
      bus.s_r_valid = 1'b1;
      bus.s_r_data  = 32'h3000 + 32'(b);
      bus.s_r_last  = (b == 3);
      #1;
      chk("t3_m1_waits", {62'd0, bus.m_ar_ready}, 64'd0);
      chk("t3_gnt_held", {62'd0, gnt}, 64'd1);
      tick();
    end
    bus.s_r_valid = 1'b0;
    bus.s_r_last  = 1'b0;
    chk("t3_idle_gnt", {62'd0, gnt}, 64'd0);
    chk("t3_idle_ar_valid", {63'd0, bus.s_ar_valid}, 64'd0);
    do_ar(2'b10, 32'h400, 8'd1);
    bus.m_ar_valid = 2'b00;

    // Backpressure on granted master 1 for 3 cycles
    bus.m_r_ready = 2'b01;
    bus.s_r_valid = 1'b1;
    bus.s_r_data  = 32'hBEEF_0000;
    bus.s_r_last  = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("t4_s_r_ready_low", {63'd0, bus.s_r_ready}, 64'd0);
      chk("t4_m_r_valid", {62'd0, bus.m_r_valid}, 64'd2);
      chk("t4_data_stable", {32'd0, bus.m_r_data}, 64'hBEEF_0000);
      tick();
    end
    bus.m_r_ready = 2'b10;
    #1;
    chk("t4_s_r_ready_high", {63'd0, bus.s_r_ready}, 64'd1);
    tick();
    run_beats(2'b10, 1, 0, 32'hBEEF_0001);
    bus.m_r_ready = 2'b11;
    chk("t4_no_proto_err", {63'd0, proto_err}, 64'd0);
    chk("t4_gnt_idle", {62'd0, gnt}, 64'd0);

    // len 2 but r_last on beat 2 -> sticky proto_err
    bus.m_ar_valid = 2'b01;
    bus.m_ar_addr  = {32'h0, 32'h0000_0500};
    bus.m_ar_len   = {8'd0, 8'd2};
    do_ar(2'b01, 32'h500, 8'd2);
    bus.m_ar_valid = 2'b00;
    run_beats(2'b01, 2, 1, 32'h5000);
    chk("t5_proto_err_set", {63'd0, proto_err}, 64'd1);
    chk("t5_gnt_idle", {62'd0, gnt}, 64'd0);
    bus.m_ar_valid = 2'b10;
    do_ar(2'b10, 32'h0, 8'd0);
    bus.m_ar_valid = 2'b00;
    run_beats(2'b10, 1, 0, 32'h5100);
    chk("t5_proto_err_sticky", {63'd0, proto_err}, 64'd1);
    do_reset();
    chk("t5_proto_err_cleared", {63'd0, proto_err}, 64'd0);

    // Reset during DATA beat 1 of len 7
    bus.m_ar_valid = 2'b01;
    bus.m_ar_addr  = {32'h0, 32'h0000_0700};
    bus.m_ar_len   = {8'd0, 8'd7};
    do_ar(2'b01, 32'h700, 8'd7);
    run_beats(2'b01, 1, 7, 32'h7000);
    bus.s_r_valid = 1'b1;
    bus.s_r_data  = 32'h7001;
    areset        = 1'b1;
    #1;
    chk("t6_pre_rst_r_valid", {62'd0, bus.m_r_valid}, 64'd1);
    tick();
    chk("t6_gnt", {62'd0, gnt}, 64'd0);
    chk("t6_ar_valid", {63'd0, bus.s_ar_valid}, 64'd0);
    chk("t6_r_ready", {63'd0, bus.s_r_ready}, 64'd0);
    chk("t6_proto_err", {63'd0, proto_err}, 64'd0);
    chk("t6_m_r_valid", {62'd0, bus.m_r_valid}, 64'd0);
    areset         = 1'b0;
    bus.s_r_valid  = 1'b0;
    bus.m_ar_valid = 2'b00;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
